ddot_rr_scheduler: RTL and testbench

// - Shares one 8-lane dot-product datapath between NREQ requesters. The datapath is an FP multiply stage

---
 rtl/ddot_pkg.sv | 22 ++
 rtl/ddot_tag_pipe.sv | 34 +++
 rtl/ddot_rr_scheduler.sv | 140 ++++++++++++++
 tb/tb_ddot_rr_scheduler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddot_pkg.sv
// Shared constants and types for the round-robin dot-product scheduler.
package ddot_pkg;
  localparam int DDOT_LANES = 8;
  localparam int FP_W       = 32;
  localparam int CHUNK_W    = DDOT_LANES * FP_W;
  localparam int TAG_ID_W   = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                last;
  } ddot_tag_t;

  function automatic int wrap_inc(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction
endpackage

// File: rtl/ddot_tag_pipe.sv
// Latency-matched tag shift register with synchronous clear.
// The MSB of each entry is its valid bit.
module ddot_tag_pipe #(
  parameter int LAT = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic         o_any_valid
);
  logic [W-1:0] r_stage [LAT];
  logic         w_any;

  // Shift one stage per cycle; reset drops every in-flight tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < LAT; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  // OR of all stage valid bits.
  always_comb begin
    w_any = 1'b0;
    for (int i = 0; i < LAT; i++) w_any = w_any | r_stage[i][W-1];
  end

  assign o_q         = r_stage[LAT-1];
  assign o_any_valid = w_any;
endmodule

// File: rtl/ddot_rr_scheduler.sv
// Round-robin, packet-locking scheduler feeding one shared 8-lane dot-product datapath
// and returning results tagged with the owning requester.
module ddot_rr_scheduler
  import ddot_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT  = 4,
  parameter int ID_W = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_last,
  input  logic [NREQ*CHUNK_W-1:0] req_x,
  input  logic [NREQ*CHUNK_W-1:0] req_y,
  output logic [NREQ-1:0]         req_ready,
  output logic [CHUNK_W-1:0]      dp_x,
  output logic [CHUNK_W-1:0]      dp_y,
  input  logic [FP_W-1:0]         dp_z,
  output logic                    res_valid,
  output logic [ID_W-1:0]         res_id,
  output logic                    res_last,
  output logic [FP_W-1:0]         res_z,
  output logic                    busy
);
  sched_state_e     r_state, w_state_nxt;
  logic [ID_W-1:0]  r_lock_id, w_lock_nxt;
  logic [ID_W-1:0]  r_rr_ptr, w_ptr_nxt;
  logic [ID_W-1:0]  w_scan_id [NREQ];
  logic             w_grant_any;
  logic [ID_W-1:0]  w_grant_id;
  logic             w_grant_last;
  logic [CHUNK_W-1:0] w_sel_x, w_sel_y;
  logic [ID_W+1:0]  r_issue_tag;
  logic [ID_W+1:0]  w_tail;
  logic             w_pipe_busy;
  ddot_tag_t        w_tail_tag;

  // Requester ids in round-robin scan order starting at the pointer.
  always_comb begin
    for (int k = 0; k < NREQ; k++) w_scan_id[k] = ID_W'((int'(r_rr_ptr) + k) % NREQ);
  end

  // Arbitration: scanning downward lets the entry closest to the pointer win.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    case (r_state)
      ST_LOCK: begin
        w_grant_any = req_valid[r_lock_id];
        w_grant_id  = r_lock_id;
      end
      ST_IDLE: begin
        for (int k = NREQ - 1; k >= 0; k--) begin
          w_grant_id  = req_valid[w_scan_id[k]] ? w_scan_id[k] : w_grant_id;
          w_grant_any = w_grant_any | req_valid[w_scan_id[k]];
        end
      end
      default: begin
        w_grant_any = 1'b0;
        w_grant_id  = '0;
      end
    endcase
    w_grant_last = w_grant_any & req_last[w_grant_id];
  end

  // One-hot ready and the granted chunk; no grant selects an all-zero bubble.
  always_comb begin
    req_ready = '0;
    w_sel_x   = '0;
    w_sel_y   = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_ready[k] = w_grant_any && (int'(w_grant_id) == k);
      w_sel_x = w_sel_x | ({CHUNK_W{req_ready[k]}} & req_x[k*CHUNK_W +: CHUNK_W]);
      w_sel_y = w_sel_y | ({CHUNK_W{req_ready[k]}} & req_y[k*CHUNK_W +: CHUNK_W]);
    end
  end

  // Packet lock and pointer update; the pointer only moves at a packet end.
  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_id;
    w_ptr_nxt   = r_rr_ptr;
    if (w_grant_any) begin
      if (w_grant_last) begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = ID_W'(wrap_inc(int'(w_grant_id), NREQ));
      end else begin
        w_state_nxt = ST_LOCK;
        w_lock_nxt  = w_grant_id;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, issue registers and the tag that travels alongside dp_x/dp_y.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_lock_id   <= '0;
      r_rr_ptr    <= '0;
      dp_x        <= '0;
      dp_y        <= '0;
      r_issue_tag <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_id   <= w_lock_nxt;
      r_rr_ptr    <= w_ptr_nxt;
      dp_x        <= w_sel_x;
      dp_y        <= w_sel_y;
      r_issue_tag <= {w_grant_any, w_grant_id, w_grant_last};
    end
  end

  // The issue tag pairs with dp_x; the pipe then spans the datapath's LAT cycles.
  ddot_tag_pipe #(
    .LAT(LAT),
    .W  (ID_W + 2)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .i_d        (r_issue_tag),
    .o_q        (w_tail),
    .o_any_valid(w_pipe_busy)
  );

  // Unpack the tail tag into its fields.
  always_comb begin
    w_tail_tag.valid = w_tail[ID_W+1];
    w_tail_tag.id    = TAG_ID_W'(w_tail[ID_W:1]);
    w_tail_tag.last  = w_tail[0];
  end

  assign res_valid = w_tail_tag.valid & (int'(w_tail_tag.id) < NREQ);
  assign res_id    = w_tail_tag.id[ID_W-1:0];
  assign res_last  = w_tail_tag.last;
  assign res_z     = dp_z;
  assign busy      = (r_state == ST_LOCK) | r_issue_tag[ID_W+1] | w_pipe_busy;
endmodule

// File: tb/tb_ddot_rr_scheduler.sv
// Table-driven bench for ddot_rr_scheduler with a behavioural LAT-cycle datapath
// and a scoreboard of expected tagged results.
module tb_ddot_rr_scheduler;
  localparam int NREQ = 2;
  localparam int LAT  = 4;
  localparam int ID_W = 1;
  localparam int CW   = 256;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_last, req_ready;
  logic [NREQ*CW-1:0] req_x, req_y;
  logic [CW-1:0]     dp_x, dp_y;
  logic [31:0]       dp_z, res_z;
  logic              res_valid, res_last, busy;
  logic [ID_W-1:0]   res_id;

  ddot_rr_scheduler #(.NREQ(NREQ), .LAT(LAT), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_x(req_x), .req_y(req_y), .req_ready(req_ready), .dp_x(dp_x), .dp_y(dp_y),
    .dp_z(dp_z), .res_valid(res_valid), .res_id(res_id), .res_last(res_last),
    .res_z(res_z), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real sp2r(input logic [31:0] b);
    logic [10:0] de;
    if (b[30:0] == 31'd0) return 0.0;
    de = 11'(int'(b[30:23]) - 127 + 1023);
    return $bitstoreal({b[31], de, b[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int ee;
    if (r == 0.0) return 32'd0;
    d  = $realtobits(r);
    ee = int'(d[62:52]) - 1023 + 127;
    return {d[63], ee[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] dot8(input logic [CW-1:0] x, input logic [CW-1:0] y);
    real acc;
    acc = 0.0;
    for (int k = 0; k < 8; k++) acc = acc + sp2r(x[k*32 +: 32]) * sp2r(y[k*32 +: 32]);
    return r2sp(acc);
  endfunction

  // Behavioural datapath: captures dp_x/dp_y at an edge, result visible LAT cycles later.
  logic [31:0] z_line [LAT];
  always @(posedge clk) begin
    z_line[0] <= dot8(dp_x, dp_y);
    for (int i = 1; i < LAT; i++) z_line[i] <= z_line[i-1];
  end
  assign dp_z = z_line[LAT-1];

  typedef struct {
    int              due;
    logic [ID_W-1:0] id;
    logic            last;
    logic [31:0]     z;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0] v;
    logic [1:0] l;
    int a0;
    int a1;
    int s;
    int g;
  } vec_t;
  vec_t tbl [9];

  int n_vec = 0;
  int n_err = 0;
  logic [CW-1:0] exp_dx, exp_dy;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] mk_x(input int a, input int s);
    logic [CW-1:0] c;
    for (int k = 0; k < 8; k++) c[k*32 +: 32] = r2sp(real'(a + s * k));
    return c;
  endfunction

  function automatic logic [CW-1:0] mk_y(input int g);
    logic [CW-1:0] c;
    for (int k = 0; k < 8; k++) c[k*32 +: 32] = r2sp(real'(g + 2));
    return c;
  endfunction

  // One cycle: drive, check at negedge, score the expected grant, advance.
  task automatic step(input logic r, input logic [1:0] v, input logic [1:0] l,
                      input int a0, input int a1, input int s, input int g);
    logic [1:0] er;
    int         a;
    exp_t       e;
    rst       = r;
    req_valid = v;
    req_last  = l;
    req_x     = {mk_x(a1, s), mk_x(a0, s)};
    req_y     = {mk_y(1), mk_y(0)};
    @(negedge clk);
    er = (g >= 0) ? 2'(1 << g) : 2'b00;
    chk("req_ready", CW'(req_ready), CW'(er));
    chk("dp_x", dp_x, exp_dx);
    chk("dp_y", dp_y, exp_dy);
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL res_missed: result id %0d due cycle %0d never seen", e.id, e.due);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("res_valid", CW'(res_valid), CW'(1'b1));
      chk("res_id", CW'(res_id), CW'(e.id));
      chk("res_last", CW'(res_last), CW'(e.last));
      chk("res_z", CW'(res_z), CW'(e.z));
    end else begin
      chk("res_valid_idle", CW'(res_valid), CW'(1'b0));
    end
    if (g >= 0 && !r) begin
      a = (g == 0) ? a0 : a1;
      e.due  = cyc + 1 + LAT;
      e.id   = ID_W'(g);
      e.last = l[g];
      e.z    = r2sp(real'(g + 2) * real'(8 * a + 28 * s));
      sb.push_back(e);
      exp_dx = mk_x(a, s);
      exp_dy = mk_y(g);
    end else begin
      exp_dx = '0;
      exp_dy = '0;
    end
    if (r) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00, 0, 0, 0, -1);
  endtask

  initial begin
    tbl[0] = '{v: 2'b10, l: 2'b10, a0: 0, a1: 2, s: 1, g: 1};
    tbl[1] = '{v: 2'b11, l: 2'b11, a0: 3, a1: 4, s: 0, g: 0};
    tbl[2] = '{v: 2'b11, l: 2'b11, a0: 5, a1: 6, s: 1, g: 1};
    tbl[3] = '{v: 2'b11, l: 2'b11, a0: 7, a1: 1, s: 2, g: 0};
    tbl[4] = '{v: 2'b11, l: 2'b11, a0: 2, a1: 9, s: 0, g: 1};
    tbl[5] = '{v: 2'b01, l: 2'b01, a0: 4, a1: 0, s: 3, g: 0};
    tbl[6] = '{v: 2'b00, l: 2'b00, a0: 0, a1: 0, s: 0, g: -1};
    tbl[7] = '{v: 2'b01, l: 2'b01, a0: 1, a1: 0, s: 1, g: 0};
    tbl[8] = '{v: 2'b10, l: 2'b10, a0: 0, a1: 3, s: 2, g: 1};

    rst = 1'b1; req_valid = '0; req_last = '0; req_x = '0; req_y = '0;
    exp_dx = '0; exp_dy = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", CW'(req_ready), CW'(2'b00));
    chk("rst_dp_x", dp_x, '0);
    chk("rst_dp_y", dp_y, '0);
    chk("rst_res_valid", CW'(res_valid), CW'(1'b0));
    chk("rst_res_id", CW'(res_id), CW'(1'b0));
    chk("rst_res_last", CW'(res_last), CW'(1'b0));
    chk("rst_busy", CW'(busy), CW'(1'b0));

    // Single chunk from req0: 8 x (1.0 * 2.0) = 16.0
    step(1'b0, 2'b01, 2'b01, 1, 0, 0, 0);
    chk("single_busy", CW'(busy), CW'(1'b1));
    chk("single_z_const", CW'(r2sp(16.0)), CW'(32'h4180_0000));
    idle(LAT + 2);
    chk("single_busy_drained", CW'(busy), CW'(1'b0));

    // Wrap from pointer 1, contention alternating, bubbles and pointer wrap-around.
    for (int i = 0; i < 9; i++)
      step(1'b0, tbl[i].v, tbl[i].l, tbl[i].a0, tbl[i].a1, tbl[i].s, tbl[i].g);
    idle(LAT + 2);

    // Lock: req0 three-chunk packet with a two-cycle gap while req1 waits.
    step(1'b0, 2'b11, 2'b00, 1, 5, 1, 0);
    step(1'b0, 2'b10, 2'b10, 0, 5, 1, -1);
    chk("lock_busy", CW'(busy), CW'(1'b1));
    step(1'b0, 2'b10, 2'b10, 0, 5, 1, -1);
    step(1'b0, 2'b11, 2'b10, 2, 5, 1, 0);
    step(1'b0, 2'b11, 2'b11, 3, 5, 1, 0);
    step(1'b0, 2'b10, 2'b10, 0, 4, 1, 1);
    idle(LAT + 2);

    // Reset with three tags in flight and the lock held on req1.
    step(1'b0, 2'b01, 2'b01, 1, 0, 0, 0);
    step(1'b0, 2'b10, 2'b10, 0, 2, 0, 1);
    step(1'b0, 2'b10, 2'b00, 0, 3, 0, 1);
    chk("pre_rst_busy", CW'(busy), CW'(1'b1));
    step(1'b1, 2'b00, 2'b00, 0, 0, 0, -1);
    chk("post_rst_busy", CW'(busy), CW'(1'b0));
    step(1'b0, 2'b01, 2'b01, 2, 0, 1, 0);
    idle(LAT + 2);

    // Idle stretch.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'b00, 2'b00, 0, 0, 0, -1);
      chk("idle_busy", CW'(busy), CW'(1'b0));
    end
    chk("sb_empty", CW'(sb.size()), CW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
